// File: rtl/keypad_decoder.sv
// ---------------------------------------------------------------------------
// keypad_decoder
//   Sits behind the 4-column keypad scanner. Debounces presses and releases
//   on the active-low row sense lines and reports a 4-bit key code
//   (row_idx*4 + col_idx) with a one-cycle valid pulse. While any row is
//   active, `hold` stalls the scanner so the column stays put.
//
//   Optional build macro: KEYPAD_SYNC_EN
//     defined   : row_n goes through a 2-flop synchroniser and col is delayed
//                 by two matching flops, so rows and columns stay aligned.
//                 All latencies grow by 2 cycles.
//     undefined : row_n and col are used directly. row_n must already be
//                 synchronous to clk.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous, active-high reset
//     col[3:0]   in   one-hot column drive (4'b1000 = col0 ... 4'b0001 = col3)
//     row_n[3:0] in   active-low rows (row_n[3] = row0 ... row_n[0] = row3)
//     hold       out  any sampled row active (combinational)
//     key_code   out  last accepted key, held until the next accepted press
//     key_valid  out  one-cycle pulse when a press is accepted
//     key_down   out  high from press acceptance until release acceptance
//     err        out  one-cycle pulse on an illegal sample seen in IDLE
//
//   Handshake: key_valid is a pure strobe with no ready. key_code is stable
//   in the cycle key_valid is high and stays stable afterwards.
// ---------------------------------------------------------------------------
module keypad_decoder #(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   input  logic [3:0] row_n,
   output logic       hold,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       err
);

   localparam int            CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam bit            DEB_ONE  = (DEB_CYCLES == 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } state_t;

   logic [3:0] rs;
   logic [3:0] cs;

`ifdef KEYPAD_SYNC_EN
   logic [3:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [3:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;

   always_comb begin
      row_s1_d = row_n;
      row_s2_d = row_s1_q;
      col_s1_d = col;
      col_s2_d = col_s1_q;
   end

   // Reset values look like "no key, column 0" so nothing fires out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1_q <= 4'b1111;
         row_s2_q <= 4'b1111;
         col_s1_q <= 4'b1000;
         col_s2_q <= 4'b1000;
      end else begin
         row_s1_q <= row_s1_d;
         row_s2_q <= row_s2_d;
         col_s1_q <= col_s1_d;
         col_s2_q <= col_s2_d;
      end
   end

   assign rs = row_s2_q;
   assign cs = col_s2_q;
`else
   assign rs = row_n;
   assign cs = col;
`endif

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // MSB-first index: 4'b1000 -> 0, 4'b0001 -> 3. Only meaningful for one-hot.
   function automatic logic [1:0] oh_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1000: idx = 2'd0;
         4'b0100: idx = 2'd1;
         4'b0010: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   logic [3:0] rows_act;
   logic       any_row;
   logic       samp_ok;
   logic [3:0] samp_code;

   assign rows_act  = ~rs;
   assign any_row   = |rows_act;
   assign samp_ok   = is_onehot(rows_act) && is_onehot(cs);
   assign samp_code = {oh_index(rows_act), oh_index(cs)};
   assign hold      = any_row;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_down_q, key_down_d;
   logic          err_q, err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any_row) begin
               if (samp_ok) begin
                  cand_d = samp_code;
                  if (DEB_ONE) begin
                     state_d     = S_PRESSED;
                     key_code_d  = samp_code;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                  end else begin
                     state_d = S_DEBOUNCE;
                     cnt_d   = CNT_ONE;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_DEBOUNCE: begin
            if (samp_ok && (samp_code == cand_q)) begin
               if (cnt_q == CNT_LAST) begin
                  state_d     = S_PRESSED;
                  cnt_d       = '0;
                  key_code_d  = cand_q;
                  key_valid_d = 1'b1;
                  key_down_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               // Any disturbance (gap, other key, column move) restarts.
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end

         S_PRESSED: begin
            // Row/column changes while pressed are ignored: no re-trigger.
            if (!any_row) begin
               if (DEB_ONE) begin
                  state_d    = S_IDLE;
                  key_down_d = 1'b0;
               end else begin
                  state_d = S_RELEASE;
                  cnt_d   = CNT_ONE;
               end
            end
         end

         S_RELEASE: begin
            if (any_row) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = S_IDLE;
               cnt_d      = '0;
               key_down_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         err_q       <= err_d;
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;
   assign err       = err_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// ---------------------------------------------------------------------------
// tb_keypad_decoder
//   Directed bench for keypad_decoder (DEB_CYCLES = 4). Each expected event
//   (key_valid with its code, or err) is pushed with the clock edge on which
//   it must appear; a monitor pops and compares whenever the DUT strobes.
//   Level outputs (key_down, key_code, hold) are checked at chosen points.
// ---------------------------------------------------------------------------
module tb_keypad_decoder;

   localparam int EW = 32;
`ifdef KEYPAD_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] col;
   logic [3:0] row_n;
   logic       hold;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Entry layout: [31:5] edge number, [4] err event, [3:0] key code.
   logic [EW-1:0] exp_q[$];

   keypad_decoder #(.DEB_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row_n     (row_n),
      .hold      (hold),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .err       (err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic step(input logic [3:0] c, input logic [3:0] r);
      col   = c;
      row_n = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b1000, 4'b1111);
   endtask

   task automatic exp_push(input logic is_err, input logic [3:0] code, input int ahead);
      int tgt;
      tgt = cyc + ahead;
      exp_q.push_back({27'(tgt), is_err, code});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      if (!rst && (key_valid || err)) begin
         act = {27'(cyc), err, (err ? 4'd0 : key_code)};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got edge=%0d err=%0b code=%0d, none expected",
                     act[31:5], act[4], act[3:0]);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL event: got edge=%0d err=%0b code=%0d expected edge=%0d err=%0b code=%0d",
                        act[31:5], act[4], act[3:0], e[31:5], e[4], e[3:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b1;
      col   = 4'b1000;
      row_n = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_code", 32'(key_code), 0);
      chk("rst_key_valid", 32'(key_valid), 0);
      chk("rst_key_down", 32'(key_down), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_hold", 32'(hold), 0);
      rst = 1'b0;
      idle(2);

      // Clean press: col1/row1 -> code 5.
      exp_push(1'b0, 4'd5, 4 + LAT);
      col   = 4'b0100;
      row_n = 4'b1011;
`ifndef KEYPAD_SYNC_EN
      #1;
      chk("hold_first_cycle", 32'(hold), 1);
`endif
      repeat (3) step(4'b0100, 4'b1011);
      chk("hold_held", 32'(hold), 1);
      repeat (3) step(4'b0100, 4'b1011);
      chk("press5_down", 32'(key_down), 1);
      chk("press5_code", 32'(key_code), 5);

      // Release bounce: 3 idle samples, then active again.
      repeat (3) step(4'b0100, 4'b1111);
      chk("rel_bounce_down_a", 32'(key_down), 1);
      repeat (3) step(4'b0100, 4'b1011);
      chk("rel_bounce_down_b", 32'(key_down), 1);
      repeat (4 + LAT) step(4'b0100, 4'b1111);
      chk("release_down", 32'(key_down), 0);
      chk("release_code_kept", 32'(key_code), 5);

      // Press bounce: 2 active, 1 gap, then steady.
      repeat (2) step(4'b0100, 4'b1011);
      step(4'b0100, 4'b1111);
      exp_push(1'b0, 4'd5, 4 + LAT);
      repeat (6) step(4'b0100, 4'b1011);
      chk("bounce_down", 32'(key_down), 1);
      idle(5 + LAT);
      chk("bounce_release_down", 32'(key_down), 0);

      // Illegal samples in IDLE: two rows, then non-one-hot column.
      exp_push(1'b1, 4'd0, 1 + LAT);
      step(4'b1000, 4'b0011);
      idle(3);
      exp_push(1'b1, 4'd0, 1 + LAT);
      step(4'b1100, 4'b0111);
      idle(3);
      chk("err_no_down", 32'(key_down), 0);
      chk("err_code_kept", 32'(key_code), 5);

      // Boundary codes.
      exp_push(1'b0, 4'd15, 4 + LAT);
      repeat (6) step(4'b0001, 4'b1110);
      chk("code15", 32'(key_code), 15);
      idle(5 + LAT);
      chk("code15_release_down", 32'(key_down), 0);
      chk("code15_kept", 32'(key_code), 15);

      exp_push(1'b0, 4'd0, 4 + LAT);
      repeat (6) step(4'b1000, 4'b0111);
      chk("code0", 32'(key_code), 0);
      chk("code0_down", 32'(key_down), 1);
      idle(5 + LAT);

      // Reset while pressed, key still held: row2/col2 -> code 10.
      exp_push(1'b0, 4'd10, 4 + LAT);
      repeat (6) step(4'b0010, 4'b1101);
      chk("pre_rst_code", 32'(key_code), 10);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_code", 32'(key_code), 0);
      chk("async_rst_down", 32'(key_down), 0);
      chk("async_rst_valid", 32'(key_valid), 0);
      chk("async_rst_err", 32'(err), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_push(1'b0, 4'd10, 4 + LAT);
      repeat (6) step(4'b0010, 4'b1101);
      chk("post_rst_down", 32'(key_down), 1);
      chk("post_rst_code", 32'(key_code), 10);
      idle(5 + LAT);
      chk("post_rst_release", 32'(key_down), 0);

      // Drain: every expected event must have been seen.
      idle(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d still pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Downstream of the 4-column keypad scanner. Consumes the scanner's one-hot column drive and the keypad's four active-low row sense lines.
- Debounces key presses and releases, and emits a 4-bit key code with a one-cycle valid pulse.
- Drives `hold` back to the scanner's stall input (`A`). High `hold` freezes the scan on the column where a key is detected.

Parameters:
- DEB_CYCLES, 4: consecutive stable samples required to accept a press or a release. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- col  input  4  one-hot column drive from the scanner; 4'b1000=col0, 4'b0100=col1, 4'b0010=col2, 4'b0001=col3
- row_n  input  4  active-low row sense; row_n[3]=row0, row_n[2]=row1, row_n[1]=row2, row_n[0]=row3
- hold  output  1  1 when any sampled row is active; connects to the scanner's `A` input
- key_code  output  4  last accepted key, encoded as row_idx*4+col_idx
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_down  output  1  level; 1 from press acceptance until release is accepted
- err  output  1  one-cycle pulse on an illegal sample in IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, cand=0, key_code=0, key_valid=0, key_down=0, err=0. With sync enabled, the sync flops reset to row_n=4'b1111 and col=4'b1000.
- Sampled inputs: `rs` and `cs` are the raw inputs without the optional synchroniser, or the aligned synchronised copies with it.
- hold = |(~rs), combinational from `rs`.
- Sample code: valid only if `cs` is one-hot and exactly one bit of `rs` is 0. Then code = {row_idx[1:0], col_idx[1:0]}.
- key_valid and err default to 0 every cycle; they are never high for more than one cycle.
- cnt width is $clog2(DEB_CYCLES+1).
- State machine, 4 states:
  - IDLE, no row active: stay.
  - IDLE, valid sample: cand<=code, cnt<=1, go to DEBOUNCE. If DEB_CYCLES==1, go straight to PRESSED instead, with the acceptance actions below.
  - IDLE, any row active but the sample is not valid (more than one row, or `cs` not one-hot): err<=1 for one cycle, stay in IDLE.
  - DEBOUNCE, sample valid and code==cand:
    - if cnt==DEB_CYCLES-1: go to PRESSED; key_code<=cand; key_valid<=1; key_down<=1.
    - otherwise: cnt<=cnt+1.
  - DEBOUNCE, anything else (no row, a different code, or an invalid sample): go to IDLE, cnt<=0, no err.
  - PRESSED, any row active: stay. Row or column changes while pressed are ignored; there is no re-trigger.
  - PRESSED, no row active: cnt<=1, go to RELEASE. If DEB_CYCLES==1, go straight to IDLE and set key_down<=0.
  - RELEASE, no row active: cnt<=cnt+1. When cnt==DEB_CYCLES-1, go to IDLE and set key_down<=0.
  - RELEASE, any row active: go to PRESSED, cnt<=0. key_valid stays 0.
- Latency: key_valid rises on the edge that takes the DEB_CYCLES-th consecutive matching sample, counting the IDLE sample as the first. key_code updates on that same edge.
- key_code holds its value after release until the next accepted press.
- Scanner interaction: `hold` stalls the scanner, so `col` is stable while a key is held. A column change during DEBOUNCE counts as a mismatch and returns the FSM to IDLE.
- Reset asserted mid-press: the FSM returns to IDLE at once. A key still held after reset is re-debounced and produces a new key_valid pulse.

Optional Feature:
- Macro: KEYPAD_SYNC_EN.
- Defined:
  - row_n passes through a 2-flop synchroniser, reset value 4'b1111.
  - col is delayed by 2 matching flops, reset value 4'b1000, so rows and columns stay aligned.
  - hold is derived from the synchronised rows.
  - All latencies grow by 2 cycles.
- Undefined: row_n and col are used directly, and row_n must be synchronous to clk.

Test Plan (DEB_CYCLES=4, no KEYPAD_SYNC_EN unless noted):
- col=4'b0100, row_n=4'b1011 held for 6 cycles -> hold=1 from the first cycle; key_valid pulses once on the 4th sampling edge; key_code=4'd5; key_down=1.
- Bounce: row_n=4'b1011 for 2 cycles, 4'b1111 for 1 cycle, then 4'b1011 steady -> no key_valid until 4 consecutive active samples after the gap.
- Release debounce after a press: row_n=4'b1111 for 3 cycles, then active again -> state returns to PRESSED, key_down stays 1, no key_valid. Then 4 idle cycles -> key_down=0, key_code stays 5.
- In IDLE, row_n=4'b0011 with col=4'b1000 -> err=1 for exactly one cycle, no key_valid, state stays IDLE. Repeat with col=4'b1100 and row_n=4'b0111 -> err=1.
- Boundary codes: col=4'b0001 with row_n=4'b1110 -> key_code=4'd15; col=4'b1000 with row_n=4'b0111 -> key_code=4'd0.
- Assert rst while in PRESSED with the key still held -> all outputs 0 immediately. After rst drops, key_valid re-pulses 4 cycles later (6 cycles with KEYPAD_SYNC_EN).
